// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads the combinational imem and
// buffers {pc, instr} pairs toward decode with redirect/flush support.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready,
   output logic        fetch_fault
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t          fifo_q [FIFO_DEPTH];
   logic [31:0]     pc_q;
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [PW:0]     count;
   logic            fault_q;
   logic            pop, fire;

   assign imem_addr   = pc_q;
   assign out_valid   = (count != '0);
   assign out_instr   = fifo_q[rd_ptr].instr;
   assign out_pc      = fifo_q[rd_ptr].pc;
   assign fetch_fault = fault_q;

   assign pop  = out_valid && out_ready;
   // A full FIFO can still accept this cycle's word when the head is leaving.
   assign fire = !redirect_valid && ((count < DEPTH_C) || pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q    <= RESET_PC;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         fault_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         fault_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
         if (redirect_valid) begin
            // Flush wins over any push/pop; a pop this cycle is treated as consumed.
            pc_q   <= {redirect_pc[31:2], 2'b00};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (fire) begin
               fifo_q[wr_ptr] <= '{pc: pc_q, instr: imem_data};
               wr_ptr         <= wr_ptr + PW'(1);
               pc_q           <= pc_q + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({fire, pop})
               2'b10:   count <= count + (PW+1)'(1);
               2'b01:   count <= count - (PW+1)'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational 256-word imem model.
module tb_instr_fetch_unit;

   logic        clk;
   logic        reset_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;
   logic        fetch_fault;

   logic [31:0] mem [256];
   int checks = 0;
   int errors = 0;

   instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
      .out_ready(out_ready), .fetch_fault(fetch_fault)
   );

   assign imem_data = mem[imem_addr[9:2]];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and sample on the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0] = 32'h000044BB;
      mem[3] = 32'h00004430;
      mem[4] = 32'h00008610;
      mem[5] = 32'h00000431;

      // Reset state
      reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
      @(negedge clk);
      chk("rst_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_fault", {31'h0, fetch_fault}, 32'h0);

      // Streaming
      reset_n = 1'b1;
      step();
      chk("s1_valid", {31'h0, out_valid}, 32'h1);
      chk("s1_pc", out_pc, 32'h0);
      chk("s1_instr", out_instr, 32'h000044BB);
      step(); chk("s2_pc", out_pc, 32'h4);
      step(); chk("s3_pc", out_pc, 32'h8);
      step(); chk("s4_pc", out_pc, 32'hC);
      chk("s4_instr", out_instr, 32'h00004430);
      chk("s4_valid", {31'h0, out_valid}, 32'h1);

      // Backpressure from reset
      reset_n = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      step(); step();
      chk("bp_addr", imem_addr, 32'h8);
      chk("bp_pc", out_pc, 32'h0);
      chk("bp_count", {29'h0, dut.count}, 32'h2);
      step();
      chk("bp_hold", imem_addr, 32'h8);
      out_ready = 1'b1;
      step(); chk("bp_pc1", out_pc, 32'h4);
      step(); chk("bp_pc2", out_pc, 32'h8);
      step(); chk("bp_pc3", out_pc, 32'hC);

      // Redirect with FIFO full
      out_ready = 1'b0;
      step();
      chk("rd_full", {29'h0, dut.count}, 32'h2);
      redirect_valid = 1'b1; redirect_pc = 32'h0C; out_ready = 1'b1;
      step();
      redirect_valid = 1'b0;
      chk("rd_valid", {31'h0, out_valid}, 32'h0);
      chk("rd_addr", imem_addr, 32'hC);
      step();
      chk("rd_pc", out_pc, 32'hC);
      chk("rd_instr", out_instr, 32'h00004430);
      step();
      chk("rd_pc2", out_pc, 32'h10);
      chk("rd_instr2", out_instr, 32'h00008610);
      chk("rd_fault", {31'h0, fetch_fault}, 32'h0);

      // Misaligned redirect
      redirect_valid = 1'b1; redirect_pc = 32'h13;
      step();
      redirect_valid = 1'b0;
      chk("mis_fault1", {31'h0, fetch_fault}, 32'h1);
      chk("mis_addr", imem_addr, 32'h10);
      step();
      chk("mis_fault0", {31'h0, fetch_fault}, 32'h0);
      chk("mis_pc", out_pc, 32'h10);
      chk("mis_instr", out_instr, 32'h00008610);

      // Wrap past the memory size
      redirect_valid = 1'b1; redirect_pc = 32'h3FC;
      step();
      redirect_valid = 1'b0;
      chk("wr_valid", {31'h0, out_valid}, 32'h0);
      step();
      chk("wr_pc", out_pc, 32'h3FC);
      step();
      chk("wr_pc2", out_pc, 32'h400);
      chk("wr_instr2", out_instr, 32'h000044BB);

      // Async reset mid-stream with FIFO full
      out_ready = 1'b0;
      step();
      chk("ar_full", {29'h0, dut.count}, 32'h2);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_valid", {31'h0, out_valid}, 32'h0);
      chk("ar_addr", imem_addr, 32'h0);
      @(negedge clk);
      reset_n = 1'b1; out_ready = 1'b1;
      step();
      chk("ar_pc", out_pc, 32'h0);
      chk("ar_instr", out_instr, 32'h000044BB);
      step();
      chk("ar_pc2", out_pc, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
